// File: rtl/mine_pkg.sv
// Shared types, widths and the tile-snap helper for the mine controller.
package mine_pkg;

  localparam int unsigned DEFAULT_TILE_BITS = 5;
  localparam int unsigned FRAME_CNT_W       = 8;
  localparam int unsigned SCREEN_COORD_W    = 11;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    EXPLODING,
    COOLDOWN
  } mine_state_t;

  // Round to the nearest tile, saturating at the right/bottom screen edge.
  function automatic logic [SCREEN_COORD_W-1:0] snap_coord(
    input logic [SCREEN_COORD_W-1:0] p,
    input int unsigned               tile_bits
  );
    logic [SCREEN_COORD_W:0]   sum;
    logic [SCREEN_COORD_W-1:0] sat;
    logic [SCREEN_COORD_W-1:0] mask;
    sum  = {1'b0, p} + (SCREEN_COORD_W + 1)'(1 << (tile_bits - 1));
    sat  = sum[SCREEN_COORD_W] ? {SCREEN_COORD_W{1'b1}} : sum[SCREEN_COORD_W-1:0];
    mask = {SCREEN_COORD_W{1'b1}} << tile_bits;
    return sat & mask;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Frame-counted down-counter; expires on the frame pulse seen while at 1.
module frame_timer
  import mine_pkg::*;
(
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   load,
  input  logic [FRAME_CNT_W-1:0] value,
  input  logic                   startOfFrame,
  output logic                   expire
);

  logic [FRAME_CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (startOfFrame && (cnt > FRAME_CNT_W'(1))) begin
      cnt <= cnt - FRAME_CNT_W'(1);
    end
  end

  assign expire = (cnt == FRAME_CNT_W'(1)) && startOfFrame;

endmodule

// File: rtl/mine_controller.sv
// Drop-key to placed mine: tile snap, fuse, explosion window and cooldown.
module mine_controller
  import mine_pkg::*;
#(
  parameter int unsigned FUSE_FRAMES     = 120,
  parameter int unsigned EXPLODE_FRAMES  = 30,
  parameter int unsigned COOLDOWN_FRAMES = 15,
  parameter int unsigned TILE_BITS       = DEFAULT_TILE_BITS
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic                      startOfFrame,
  input  logic                      drop_req,
  input  logic [SCREEN_COORD_W-1:0] playerX,
  input  logic [SCREEN_COORD_W-1:0] playerY,
  input  logic                      chain_hit,
  output logic                      bomb_exist,
  output logic                      bomb_exploded,
  output logic [SCREEN_COORD_W-1:0] topLeftX,
  output logic [SCREEN_COORD_W-1:0] topLeftY,
  output logic                      explode_pulse,
  output logic                      busy
);

  mine_state_t            state_q, state_d;
  logic                   drop_req_d;
  logic                   drop_rise;
  logic                   load;
  logic [FRAME_CNT_W-1:0] load_val;
  logic                   accept;
  logic                   expire;

  assign drop_rise = drop_req & ~drop_req_d;

  frame_timer u_timer (
    .clk          (clk),
    .resetN       (resetN),
    .load         (load),
    .value        (load_val),
    .startOfFrame (startOfFrame),
    .expire       (expire)
  );

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_val = FRAME_CNT_W'(FUSE_FRAMES);
    accept   = 1'b0;
    case (state_q)
      IDLE: begin
        if (drop_rise) begin
          state_d  = ARMED;
          load     = 1'b1;
          load_val = FRAME_CNT_W'(FUSE_FRAMES);
          accept   = 1'b1;
        end
      end
      ARMED: begin
        if (expire || chain_hit) begin
          state_d  = EXPLODING;
          load     = 1'b1;
          load_val = FRAME_CNT_W'(EXPLODE_FRAMES);
        end
      end
      EXPLODING: begin
        if (expire) begin
          if (COOLDOWN_FRAMES == 0) begin
            state_d = IDLE;
          end else begin
            state_d  = COOLDOWN;
            load     = 1'b1;
            load_val = FRAME_CNT_W'(COOLDOWN_FRAMES);
          end
        end
      end
      COOLDOWN: begin
        if (expire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the transition edge.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q       <= IDLE;
      drop_req_d    <= 1'b0;
      bomb_exist    <= 1'b0;
      bomb_exploded <= 1'b0;
      explode_pulse <= 1'b0;
      busy          <= 1'b0;
      topLeftX      <= '0;
      topLeftY      <= '0;
    end else begin
      state_q       <= state_d;
      drop_req_d    <= drop_req;
      bomb_exist    <= (state_d == ARMED);
      bomb_exploded <= (state_d == EXPLODING);
      explode_pulse <= (state_q == ARMED) && (state_d == EXPLODING);
      busy          <= (state_d != IDLE);
      if (accept) begin
        topLeftX <= snap_coord(playerX, TILE_BITS);
        topLeftY <= snap_coord(playerY, TILE_BITS);
      end
    end
  end

endmodule

// File: tb/tb_mine_controller.sv
// Vector-table bench for mine_controller with a queue-based scoreboard.
module tb_mine_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: FUSE=3 EXPLODE=2 COOLDOWN=1; DUT B: same but COOLDOWN=0.
  logic        a_rst = 1'b0, a_sof = 1'b0, a_drop = 1'b0, a_chain = 1'b0;
  logic [10:0] a_px = '0, a_py = '0;
  logic        a_exist, a_expl, a_pulse, a_busy;
  logic [10:0] a_tlx, a_tly;

  logic        b_rst = 1'b0, b_sof = 1'b0, b_drop = 1'b0, b_chain = 1'b0;
  logic [10:0] b_px = '0, b_py = '0;
  logic        b_exist, b_expl, b_pulse, b_busy;
  logic [10:0] b_tlx, b_tly;

  mine_controller #(
    .FUSE_FRAMES(3), .EXPLODE_FRAMES(2), .COOLDOWN_FRAMES(1), .TILE_BITS(5)
  ) u_dut_a (
    .clk(clk), .resetN(a_rst), .startOfFrame(a_sof), .drop_req(a_drop),
    .playerX(a_px), .playerY(a_py), .chain_hit(a_chain),
    .bomb_exist(a_exist), .bomb_exploded(a_expl), .topLeftX(a_tlx),
    .topLeftY(a_tly), .explode_pulse(a_pulse), .busy(a_busy)
  );

  mine_controller #(
    .FUSE_FRAMES(3), .EXPLODE_FRAMES(2), .COOLDOWN_FRAMES(0), .TILE_BITS(5)
  ) u_dut_b (
    .clk(clk), .resetN(b_rst), .startOfFrame(b_sof), .drop_req(b_drop),
    .playerX(b_px), .playerY(b_py), .chain_hit(b_chain),
    .bomb_exist(b_exist), .bomb_exploded(b_expl), .topLeftX(b_tlx),
    .topLeftY(b_tly), .explode_pulse(b_pulse), .busy(b_busy)
  );

  // exp = {exist, exploded, pulse, busy, topLeftX, topLeftY}
  typedef struct packed {
    logic        sel;
    logic        rst;
    logic        drop;
    logic        sof;
    logic        chain;
    logic [10:0] px;
    logic [10:0] py;
    logic [25:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [25:0] sb[$];
  int          n_vec = 0;
  int          n_err = 0;

  function automatic vec_t v(input logic sel, input logic rst, input logic drop,
                             input logic sof, input logic chain, input int px,
                             input int py, input logic ex, input logic xp,
                             input logic pu, input logic bs, input int tx,
                             input int ty);
    vec_t r;
    r.sel = sel; r.rst = rst; r.drop = drop; r.sof = sof; r.chain = chain;
    r.px = 11'(px); r.py = 11'(py);
    r.exp = {ex, xp, pu, bs, 11'(tx), 11'(ty)};
    return r;
  endfunction

  function automatic logic [25:0] out_a();
    return {a_exist, a_expl, a_pulse, a_busy, a_tlx, a_tly};
  endfunction

  function automatic logic [25:0] out_b();
    return {b_exist, b_expl, b_pulse, b_busy, b_tlx, b_tly};
  endfunction

  task automatic chk(input string name, input logic [25:0] act, input logic [25:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got ex=%b xp=%b pu=%b bs=%b tl=(%0d,%0d) want ex=%b xp=%b pu=%b bs=%b tl=(%0d,%0d)",
               name, act[25], act[24], act[23], act[22], act[21:11], act[10:0],
               req[25], req[24], req[23], req[22], req[21:11], req[10:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    logic [25:0] want;

    // ---- DUT A: basic drop, snap, fuse, explode, cooldown
    vecs.push_back(v(0, 0, 0, 0, 0,    0,   0, 0, 0, 0, 0,    0,  0));
    vecs.push_back(v(0, 1, 0, 0, 0,    0,   0, 0, 0, 0, 0,    0,  0));
    vecs.push_back(v(0, 1, 1, 0, 0,   47, 100, 1, 0, 0, 1,   32, 96));
    vecs.push_back(v(0, 1, 0, 1, 0,   47, 100, 1, 0, 0, 1,   32, 96));
    vecs.push_back(v(0, 1, 0, 0, 0,   47, 100, 1, 0, 0, 1,   32, 96));
    vecs.push_back(v(0, 1, 0, 1, 0,   47, 100, 1, 0, 0, 1,   32, 96));
    vecs.push_back(v(0, 1, 0, 1, 0,   47, 100, 0, 1, 1, 1,   32, 96));
    vecs.push_back(v(0, 1, 0, 0, 0,   47, 100, 0, 1, 0, 1,   32, 96));
    vecs.push_back(v(0, 1, 0, 1, 0,   47, 100, 0, 1, 0, 1,   32, 96));
    vecs.push_back(v(0, 1, 0, 1, 0,   47, 100, 0, 0, 0, 1,   32, 96));
    // Rise coinciding with COOLDOWN->IDLE is dropped; held key gives no new rise.
    vecs.push_back(v(0, 1, 1, 1, 0,  300, 300, 0, 0, 0, 0,   32, 96));
    vecs.push_back(v(0, 1, 1, 0, 0,  300, 300, 0, 0, 0, 0,   32, 96));
    vecs.push_back(v(0, 1, 0, 0, 0,  300, 300, 0, 0, 0, 0,   32, 96));
    // Saturating snap at the right edge, Y at zero.
    vecs.push_back(v(0, 1, 1, 0, 0, 2040,   0, 1, 0, 0, 1, 2016,  0));
    vecs.push_back(v(0, 1, 0, 0, 0,  500, 500, 1, 0, 0, 1, 2016,  0));
    vecs.push_back(v(0, 1, 1, 0, 0,  500, 500, 1, 0, 0, 1, 2016,  0));
    // Chain hit while armed; then ignored while exploding.
    vecs.push_back(v(0, 1, 0, 0, 1,  500, 500, 0, 1, 1, 1, 2016,  0));
    vecs.push_back(v(0, 1, 0, 0, 1,  500, 500, 0, 1, 0, 1, 2016,  0));
    vecs.push_back(v(0, 1, 0, 1, 0,  500, 500, 0, 1, 0, 1, 2016,  0));
    // Reset mid-explosion.
    vecs.push_back(v(0, 0, 0, 0, 0,  500, 500, 0, 0, 0, 0,    0,  0));
    vecs.push_back(v(0, 1, 0, 1, 0,  500, 500, 0, 0, 0, 0,    0,  0));
    // Chain hit together with the final fuse frame.
    vecs.push_back(v(0, 1, 1, 0, 0,   48,  48, 1, 0, 0, 1,   64, 64));
    vecs.push_back(v(0, 1, 0, 1, 0,   48,  48, 1, 0, 0, 1,   64, 64));
    vecs.push_back(v(0, 1, 0, 1, 0,   48,  48, 1, 0, 0, 1,   64, 64));
    vecs.push_back(v(0, 1, 0, 1, 1,   48,  48, 0, 1, 1, 1,   64, 64));
    vecs.push_back(v(0, 1, 0, 0, 1,   48,  48, 0, 1, 0, 1,   64, 64));
    vecs.push_back(v(0, 0, 0, 0, 0,    0,   0, 0, 0, 0, 0,    0,  0));
    vecs.push_back(v(0, 1, 0, 0, 0,    0,   0, 0, 0, 0, 0,    0,  0));
    // ---- DUT B: no cooldown, immediate re-drop accepted
    vecs.push_back(v(1, 0, 0, 0, 0,    0,   0, 0, 0, 0, 0,    0,  0));
    vecs.push_back(v(1, 1, 0, 0, 0,    0,   0, 0, 0, 0, 0,    0,  0));
    vecs.push_back(v(1, 1, 1, 0, 0,    0,   0, 1, 0, 0, 1,    0,  0));
    vecs.push_back(v(1, 1, 0, 1, 0,    0,   0, 1, 0, 0, 1,    0,  0));
    vecs.push_back(v(1, 1, 0, 1, 0,    0,   0, 1, 0, 0, 1,    0,  0));
    vecs.push_back(v(1, 1, 0, 1, 0,    0,   0, 0, 1, 1, 1,    0,  0));
    vecs.push_back(v(1, 1, 0, 1, 0,    0,   0, 0, 1, 0, 1,    0,  0));
    vecs.push_back(v(1, 1, 0, 1, 0,    0,   0, 0, 0, 0, 0,    0,  0));
    vecs.push_back(v(1, 1, 1, 0, 0,  100,  31, 1, 0, 0, 1,   96, 32));

    #1;
    foreach (vecs[i]) begin
      if (vecs[i].sel == 1'b0) begin
        a_rst = vecs[i].rst; a_drop = vecs[i].drop; a_sof = vecs[i].sof;
        a_chain = vecs[i].chain; a_px = vecs[i].px; a_py = vecs[i].py;
      end else begin
        b_rst = vecs[i].rst; b_drop = vecs[i].drop; b_sof = vecs[i].sof;
        b_chain = vecs[i].chain; b_px = vecs[i].px; b_py = vecs[i].py;
      end
      sb.push_back(vecs[i].exp);
      tick();
      want = sb.pop_front();
      chk($sformatf("vec%0d", i), vecs[i].sel ? out_b() : out_a(), want);
    end

    // ---- DUT A: key held for 20 frames gives one mine, no re-arm while held
    a_px = 11'd200; a_py = 11'd200; a_chain = 1'b0;
    a_drop = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      a_sof = (i % 2 == 1);
      tick();
      pulses += int'(a_pulse);
    end
    a_sof = 1'b0;
    chk("held_pulse_count", 26'(pulses), 26'(1));
    chk("held_idle", {a_exist, a_expl, a_pulse, a_busy, 22'd0},
        {1'b0, 1'b0, 1'b0, 1'b0, 22'd0});
    a_drop = 1'b0;
    tick();
    a_drop = 1'b1;
    sb.push_back({1'b1, 1'b0, 1'b0, 1'b1, 11'd192, 11'd192});
    tick();
    want = sb.pop_front();
    chk("rearm_after_release", out_a(), want);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mine_controller.md
Name: mine_controller

Overview:
- Per-mine control stage directly upstream of the mine bitmap drawer.
- Turns a player "drop" key into a placed mine with these properties:
  - snapped to the 32x32 tile grid;
  - a frame-counted fuse, explosion window and cooldown.
- Drives the drawer's bomb_exist / bomb_exploded qualifiers and the mine's top-left position to the rectangle/offset stage.
- Emits a one-cycle detonation pulse for sound/score logic.

Parameters:
- FUSE_FRAMES, 120: frames from drop to detonation; legal range 1..255.
- EXPLODE_FRAMES, 30: frames explosion stays on screen; legal range 1..255.
- COOLDOWN_FRAMES, 15: frames after explosion before a new drop is accepted; legal range 0..255.
- TILE_BITS, 5: log2 of tile size (32 px).

Ports:
- clk  in  1  system clock.
- resetN  in  1  synchronous active-low reset.
- startOfFrame  in  1  one-clk pulse per video frame.
- drop_req  in  1  drop key level from keyboard decoder.
- playerX  in  11  player top-left X, pixels.
- playerY  in  11  player top-left Y, pixels.
- chain_hit  in  1  level; another explosion covers this mine.
- bomb_exist  out  1  mine armed and visible.
- bomb_exploded  out  1  explosion active.
- topLeftX  out  11  mine top-left X, tile-aligned.
- topLeftY  out  11  mine top-left Y, tile-aligned.
- explode_pulse  out  1  one clk high on entering EXPLODING.
- busy  out  1  state != IDLE.

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-low (resetN), sampled on posedge clk only.
- Reset values: state IDLE; bomb_exist=0, bomb_exploded=0, topLeftX=0, topLeftY=0, explode_pulse=0, busy=0; frame counter 0; edge-detect register 0.
- All outputs are registered. Each output reflects the state entered on the same clock edge as the transition.
- Drop edge: drop_rise = drop_req & ~drop_req_d. drop_req_d is registered every clk. A held key gives exactly one rise.
- Position snap, per axis:
  - sum = {1'b0,player} + 2^(TILE_BITS-1), computed 12 bits wide;
  - if sum > 2047, use 2047;
  - then clear the low TILE_BITS bits.
  - Example: playerX=47 gives 63, snaps to 32. playerX=48 gives 64, snaps to 64. playerX=2040 saturates, giving 2016.
  - Snap is captured only on the accepted drop; topLeft holds until the next accepted drop.
- State machine: IDLE, ARMED, EXPLODING, COOLDOWN.
- IDLE:
  - On drop_rise: go to ARMED, counter = FUSE_FRAMES, latch snapped position.
  - A startOfFrame in the same clk does not decrement.
- ARMED, bomb_exist=1:
  - On startOfFrame, counter decrements.
  - When counter==1 and startOfFrame, or when chain_hit=1: go to EXPLODING, counter = EXPLODE_FRAMES, explode_pulse=1 for one clk.
  - Fuse expiry and chain_hit in the same clk produce a single transition and a single pulse.
- EXPLODING, bomb_exploded=1, bomb_exist=0:
  - Decrement on startOfFrame. At counter==1 with startOfFrame:
    - if COOLDOWN_FRAMES==0, go to IDLE;
    - else go to COOLDOWN with counter = COOLDOWN_FRAMES.
  - chain_hit is ignored.
- COOLDOWN, both flags 0, busy=1: decrement on startOfFrame. At counter==1 with startOfFrame, go to IDLE.
- Drop handling outside IDLE: drop_rise is ignored and not queued. A rise in the same clk as the COOLDOWN-to-IDLE transition is ignored.
- Reset mid-operation: from any state, next clk is IDLE with all outputs at reset values. No pulse is generated.
- Counter: 8 bits, unsigned, never decremented below 1 while in a timed state.

Decomposition:
- Package mine_pkg:
  - state enum mine_state_t {IDLE, ARMED, EXPLODING, COOLDOWN};
  - TILE_BITS default;
  - FRAME_CNT_W=8;
  - SCREEN_COORD_W=11.
- Sub-module frame_timer:
  - load / value / startOfFrame in, expire out;
  - 8-bit down-counter;
  - expire = (cnt==1) & startOfFrame.
  - Instantiated once. The FSM owns load values.

Test Plan (FUSE=3, EXPLODE=2, COOLDOWN=1 unless stated):
- Reset, then one clk of drop_req with playerX=47, playerY=100:
  - next clk: bomb_exist=1, topLeft=(32,96), busy=1.
  - after 3 startOfFrame pulses: bomb_exploded=1, bomb_exist=0, explode_pulse high exactly 1 clk.
  - after 2 more: both flags 0, busy=1.
  - after 1 more: busy=0.
- drop_req held high 20 frames:
  - only one mine.
  - after cooldown, no re-arm until drop_req falls and rises again.
- ARMED, counter=3, chain_hit pulses:
  - EXPLODING next clk, one explode_pulse.
  - chain_hit asserted together with the final fuse startOfFrame still gives one pulse.
- Drop during ARMED at a new player position: ignored, topLeft unchanged. playerX=2040 drop from IDLE gives topLeftX=2016.
- resetN low for one clk during EXPLODING: all outputs 0 next clk, state IDLE, explode_pulse stays 0.
- COOLDOWN_FRAMES=0: EXPLODING goes straight to IDLE on the final startOfFrame. A drop one clk later is accepted.
